// File: rtl/output_driver_pkg.sv
// Shared definitions for the output driver: per-bit FSM encodings and counter sizing.
package output_driver_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Hold counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/output_hold_cell.sv
// One output line: registered level with a minimum hold window and busy flag.
module output_hold_cell
    import output_driver_pkg::*;
#(
    parameter int unsigned MIN_HOLD_CYCLES = 4,
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic in_i,
    output logic out_o,
    output logic busy_o
);

    localparam int unsigned CNT_W = cnt_width(MIN_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MIN_HOLD_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= RESET_BIT;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    // Input is only sampled when idle or when the hold window has expired.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_i != out_q) begin
                    out_d   = in_i;
                    cnt_d   = RELOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (in_i != out_q) begin
                    out_d = in_i;
                    cnt_d = RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_HOLD);
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/output_driver.sv
// Registers internal sys_clk-domain levels and output-enable onto external pins,
// enforcing a minimum level duration on every line.
module output_driver
    import output_driver_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      MIN_HOLD_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_line,
    input  logic             out_en,
    output logic [WIDTH-1:0] out_line,
    output logic             oe_line,
    output logic [WIDTH-1:0] busy
);

    logic oe_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_q <= 1'b0;
        end else begin
            oe_q <= out_en;
        end
    end

    assign oe_line = oe_q;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        output_hold_cell #(
            .MIN_HOLD_CYCLES(MIN_HOLD_CYCLES),
            .RESET_BIT      (RESET_VALUE[i])
        ) u_cell (
            .sys_clk(sys_clk),
            .rst_n  (rst_n),
            .in_i   (in_line[i]),
            .out_o  (out_line[i]),
            .busy_o (busy[i])
        );
    end

endmodule
